// File: rtl/ofifo_drain_pkg.sv
// Shared types and constants for the output-FIFO drain controller.
// Holds the lane geometry, read latency, state encodings and launch config.
package ofifo_drain_pkg;

    localparam int unsigned COL    = 8;
    localparam int unsigned BW     = 4;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DATA_W = COL * BW;
    localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_VALID = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_WAIT_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE      = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_WAIT_VALID = ST_WAIT_VALID,
        S_ISSUE      = ST_ISSUE,
        S_WAIT_DATA  = ST_WAIT_DATA,
        S_WRITE      = ST_WRITE,
        S_DONE       = ST_DONE
    } state_e;

    // Job parameters latched at launch and held for the whole drain.
    typedef struct packed {
        logic [ADDR_W-1:0] num_words;
        logic              relu_en;
    } cfg_t;

    // The capture is timed by a down-counter, so a zero latency cannot work.
    function automatic bit rd_lat_ok(input int unsigned lat);
        return lat >= 1;
    endfunction

endpackage

// File: rtl/ofifo_drain_if.sv
// Launch, output-FIFO read side and psum-SRAM write side of the drain block.
// master is the drain controller; slave is its environment.
interface ofifo_drain_if;
    import ofifo_drain_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] num_words;
    logic [ADDR_W-1:0] base_addr;
    logic              relu_en;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_d;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_words, base_addr, relu_en, fifo_valid, fifo_data,
        output fifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

    modport slave (
        output start, num_words, base_addr, relu_en, fifo_valid, fifo_data,
        input  fifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

endinterface

// File: rtl/ofifo_drain_relu_lane.sv
// Single-lane ReLU: clamps a negative two's-complement lane to zero when enabled.
module relu_lane #(
    parameter int unsigned bw = 4
) (
    input  logic          en,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout_c
);

    always_comb begin
        dout_c = din;
        if (en && din[bw-1]) begin
            dout_c = '0;
        end
    end

endmodule

// File: rtl/ofifo_drain.sv
// Drains complete rows from the output FIFO into consecutive psum-SRAM words,
// one outstanding read at a time, with an optional per-lane ReLU on the way.
module ofifo_drain
    import ofifo_drain_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ofifo_drain_if.master bus
);

    if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_chk
        $error("ofifo_drain: RD_LAT must be at least 1");
    end

    state_e            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              wr_n_q, wr_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] relu_word;

    // Next-state, counters and capture; output flops follow the next state.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        cap_d   = cap_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_words != '0) begin
                        cfg_d.num_words = bus.num_words;
                        cfg_d.relu_en   = bus.relu_en;
                        idx_d           = '0;
                        addr_d          = bus.base_addr;
                        state_d         = S_WAIT_VALID;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_VALID: begin
                if (bus.fifo_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_W'(RD_LAT);
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                // Data is taken purely by latency count; fifo_valid is ignored here.
                if (lat_q == LAT_W'(1)) begin
                    cap_d   = bus.fifo_data;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + ADDR_W'(1);
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (idx_d == cfg_q.num_words) ? S_DONE : S_WAIT_VALID;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fifo_rd_d = (state_d == S_ISSUE);
        wr_n_d    = (state_d != S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            lat_q     <= '0;
            cap_q     <= '0;
            fifo_rd_q <= 1'b0;
            wr_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            cap_q     <= cap_d;
            fifo_rd_q <= fifo_rd_d;
            wr_n_q    <= wr_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    for (genvar i = 0; i < COL; i++) begin : g_relu
        relu_lane #(.bw(BW)) u_relu_lane (
            .en     (cfg_q.relu_en),
            .din    (cap_q[i*BW +: BW]),
            .dout_c (relu_word[i*BW +: BW])
        );
    end

    // addr_q already holds base+idx while in WRITE; it advances on the way out.
    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.sram_cen  = wr_n_q;
    assign bus.sram_wen  = wr_n_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_d    = relu_word;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ofifo_drain.sv
// Bench for ofifo_drain: FIFO model with read latency, SRAM-write scoreboard,
// a ReLU vector table and hand-written multi-cycle corner sequences.
module tb_ofifo_drain;
    import ofifo_drain_pkg::*;

    logic clk = 1'b0;
    logic reset;

    ofifo_drain_if bus ();

    ofifo_drain dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic              relu;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dexp;
    } vec_t;

    wr_t exp_q[$];
    int  rd_cyc[$];
    int  wr_cyc[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;

    // FIFO model: rows become visible RD_LAT cycles after a pop.
    logic [DATA_W-1:0] mem [64];
    logic [5:0]        wr_ptr = '0;
    logic [5:0]        rd_ptr = '0;
    int                stale_cnt = 0;
    bit                stale_mode = 1'b0;
    logic [DATA_W-1:0] pipe [RD_LAT];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            rd_ptr    <= wr_ptr;
            stale_cnt <= 0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            if (bus.fifo_rd) begin
                pipe[0] <= (rd_ptr != wr_ptr) ? mem[rd_ptr] : 32'hDEADBEEF;
                if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 6'd1;
                stale_cnt <= (stale_mode && (rd_ptr + 6'd1 == wr_ptr)) ? RD_LAT : 0;
            end else begin
                pipe[0] <= 32'hA5A5A5A5;
                if (stale_cnt > 0) stale_cnt <= stale_cnt - 1;
            end
        end
    end

    assign bus.fifo_valid = (rd_ptr != wr_ptr) || (stale_cnt != 0);
    assign bus.fifo_data  = pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: logs reads/done and checks every SRAM write against the scoreboard.
    initial begin : mon
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.fifo_rd) rd_cyc.push_back(cyc);
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!bus.sram_cen && !bus.sram_wen) begin
                    wr_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wr_extra: got write addr=%0h data=%0h expected none", bus.sram_addr, bus.sram_d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(bus.sram_addr), 64'(e.addr));
                        chk("wr_data", 64'(bus.sram_d), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rd_cyc.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic load(input logic [DATA_W-1:0] w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] e);
        wr_t x;
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
        x.addr = a;
        x.data = e;
        exp_q.push_back(x);
    endtask

    task automatic launch(input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] a,
                          input logic r, output int s_cyc);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_words = n;
        bus.base_addr = a;
        bus.relu_en = r;
        s_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    task automatic end_run(input string name, input int n);
        repeat (6) @(posedge clk);
        chk({name, "_rd"}, 64'(rd_cyc.size()), 64'(n));
        chk({name, "_wr"}, 64'(wr_cyc.size()), 64'(n));
        chk({name, "_sb"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_done"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_fifo_rd"}, 64'(bus.fifo_rd), 64'd0);
        chk({name, "_cen"}, 64'(bus.sram_cen), 64'd1);
        chk({name, "_wen"}, 64'(bus.sram_wen), 64'd1);
        chk({name, "_addr"}, 64'(bus.sram_addr), 64'd0);
        chk({name, "_d"}, 64'(bus.sram_d), 64'd0);
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_done"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vec[7];

    initial begin
        int s;
        int v;
        int k;
        logic [DATA_W-1:0] w4 [4];

        vec[0] = '{1'b0, 32'h12345678, 32'h12345678};
        vec[1] = '{1'b1, 32'h8F7F1234, 32'h00701234};
        vec[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000000};
        vec[3] = '{1'b1, 32'h77777777, 32'h77777777};
        vec[4] = '{1'b0, 32'h89ABCDEF, 32'h89ABCDEF};
        vec[5] = '{1'b1, 32'h1A2B3C4D, 32'h10203040};
        vec[6] = '{1'b1, 32'h08080808, 32'h00000000};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_words = '0;
        bus.base_addr = '0;
        bus.relu_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic three-row drain
        clear_logs();
        load(32'h12345678, 11'h010, 32'h12345678);
        load(32'h9ABCDEF0, 11'h011, 32'h9ABCDEF0);
        load(32'h0F0F0F0F, 11'h012, 32'h0F0F0F0F);
        launch(11'd3, 11'h010, 1'b0, s);
        wait_done("basic", 100);
        end_run("basic", 3);
        chk("basic_start_to_rd", 64'(rd_cyc[0] - s), 64'd2);
        chk("basic_period0", 64'(wr_cyc[1] - wr_cyc[0]), 64'd5);
        chk("basic_period1", 64'(wr_cyc[2] - wr_cyc[1]), 64'd5);
        chk("basic_done_lag", 64'(done_cyc - wr_cyc[2]), 64'd1);

        // ReLU / passthrough vector table, one row per job
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            load(vec[i].din, ADDR_W'(11'h100 + i), vec[i].dexp);
            launch(11'd1, ADDR_W'(11'h100 + i), vec[i].relu, s);
            wait_done("tbl", 50);
            end_run("tbl", 1);
        end

        // Starvation, then valid arrives
        clear_logs();
        launch(11'd1, 11'h040, 1'b0, s);
        repeat (20) @(posedge clk);
        chk("starve_rd", 64'(rd_cyc.size()), 64'd0);
        chk("starve_wr", 64'(wr_cyc.size()), 64'd0);
        chk("starve_busy", 64'(bus.busy), 64'd1);
        #1;
        load(32'hCAFEF00D, 11'h040, 32'hCAFEF00D);
        v = cyc;
        wait_done("starve", 50);
        end_run("starve", 1);
        chk("starve_rd_lag", 64'(rd_cyc[0] - v), 64'd1);

        // Zero-length job
        clear_logs();
        launch(11'd0, 11'h123, 1'b0, s);
        wait_done("zero", 20);
        end_run("zero", 0);
        chk("zero_done_lag", 64'(done_cyc - s), 64'd1);

        // Address wrap with a start pulse while busy
        clear_logs();
        w4[0] = 32'h11112222; w4[1] = 32'h33334444; w4[2] = 32'h55556666; w4[3] = 32'h0000ABCD;
        for (int i = 0; i < 4; i++) load(w4[i], ADDR_W'(2046 + i), w4[i]);
        launch(11'd4, 11'd2046, 1'b0, s);
        repeat (3) @(posedge clk); #1;
        bus.start = 1'b1; bus.num_words = 11'd1; bus.base_addr = 11'h555;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("wrap", 100);
        repeat (10) @(posedge clk);
        end_run("wrap", 4);

        // Reset in WAIT_DATA of the second of five rows
        clear_logs();
        for (int i = 0; i < 5; i++) load(32'h20000000 + DATA_W'(i), ADDR_W'(11'h200 + i), 32'h20000000 + DATA_W'(i));
        launch(11'd5, 11'h200, 1'b0, s);
        k = 0;
        while (rd_cyc.size() < 2 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("mid_second_rd", 64'(rd_cyc.size()), 64'd2);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("mid_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (8) @(posedge clk);
        chk("mid_wr_before_rst", 64'(wr_cyc.size()), 64'd1);
        clear_logs();
        load(32'hFEDC0123, 11'h300, 32'hFEDC0123);
        load(32'h4567ABCD, 11'h301, 32'h4567ABCD);
        launch(11'd2, 11'h300, 1'b0, s);
        wait_done("restart", 100);
        end_run("restart", 2);

        // Stale valid after the last pop
        stale_mode = 1'b1;
        clear_logs();
        load(32'hAAAA5555, 11'h020, 32'hAAAA5555);
        load(32'h5555AAAA, 11'h021, 32'h5555AAAA);
        load(32'h01234567, 11'h022, 32'h01234567);
        launch(11'd3, 11'h020, 1'b0, s);
        wait_done("stale", 100);
        repeat (10) @(posedge clk);
        end_run("stale", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
